// File: rtl/mul_pkg.sv
// Shared types and saturation helper for the multiplier exponent path.
// Optional sticky flags are enabled by MUL_EXP_STICKY_FLAGS_EN.
package mul_pkg;

    localparam int unsigned EXP_W_DEF = 4;
    localparam int unsigned BIAS_DEF  = 7;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic zero;
    } flags_t;

    typedef struct packed {
        logic [7:0] res;
        flags_t     flg;
    } sat_t;

    // Remove the bias once and clamp into [0, 2^exp_w-1].
    function automatic sat_t exp_sat(
        input logic [8:0]  sum,
        input logic        zero,
        input int unsigned bias,
        input int unsigned exp_w
    );
        sat_t s;
        int   r;
        int   mx;
        s  = '0;
        r  = int'(sum) - int'(bias);
        mx = (1 << exp_w) - 1;
        if (zero) begin
            s.flg.zero = 1'b1;
        end else if (r > mx) begin
            s.res     = 8'(mx);
            s.flg.ovf = 1'b1;
        end else if (r <= 0) begin
            s.flg.unf = 1'b1;
        end else begin
            s.res = 8'(r);
        end
        return s;
    endfunction

endpackage

// File: rtl/mul_exp_pipe_if.sv
// Operand/result handshake bundle for the exponent pipeline.
// Sticky flag signals are only live with MUL_EXP_STICKY_FLAGS_EN.
interface mul_exp_pipe_if
    import mul_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] exp1;
    logic [EXP_W-1:0] exp2;
    logic             norm_inc;
    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] result;
    logic             ovf;
    logic             unf;
    logic             zero;
    logic             flag_clr;
    logic             sticky_ovf;
    logic             sticky_unf;

    modport slave (
        input  in_valid, exp1, exp2, norm_inc,
        input  out_ready, flag_clr,
        output in_ready, out_valid, result,
        output ovf, unf, zero,
        output sticky_ovf, sticky_unf
    );

    modport master (
        output in_valid, exp1, exp2, norm_inc,
        output out_ready, flag_clr,
        input  in_ready, out_valid, result,
        input  ovf, unf, zero,
        input  sticky_ovf, sticky_unf
    );
endinterface

// File: rtl/mul_exp_stage.sv
// Generic valid/ready pipeline register with a W-bit payload.
// Payload only loads on a valid beat so idle cycles do not toggle it.
module mul_exp_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end
endmodule

// File: rtl/mul_exp_pipe.sv
// Two-stage biased exponent adder with saturation and flags.
// Define MUL_EXP_STICKY_FLAGS_EN to add sticky ovf/unf flags.
module mul_exp_pipe
    import mul_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned BIAS  = BIAS_DEF
) (
    input logic           clk,
    input logic           rst_n,
    mul_exp_pipe_if.slave bus
);
    localparam int unsigned SW = EXP_W + 1;
    localparam int unsigned W1 = SW + 1;
    localparam int unsigned W2 = EXP_W + 3;

    logic          s1_en;
    logic          s2_en;
    logic          s1_valid;
    logic [W1-1:0] s1_d;
    logic [W1-1:0] s1_q;
    logic [SW-1:0] s1_sum;
    logic          s1_zero;
    sat_t          sat;
    logic [W2-1:0] s2_d;
    logic [W2-1:0] s2_q;

    assign s1_d = {
        SW'(bus.exp1) + SW'(bus.exp2) + SW'(bus.norm_inc),
        (bus.exp1 == '0) | (bus.exp2 == '0)
    };

    mul_exp_stage #(.W(W1)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (s1_en),
        .in_data   (s1_d),
        .out_valid (s1_valid),
        .out_ready (s2_en),
        .out_data  (s1_q)
    );

    assign bus.in_ready = s1_en;
    assign s1_sum  = s1_q[W1-1:1];
    assign s1_zero = s1_q[0];

    assign sat  = exp_sat(9'(s1_sum), s1_zero, BIAS, EXP_W);
    assign s2_d = {sat.res[EXP_W-1:0], sat.flg};

    mul_exp_stage #(.W(W2)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_en),
        .in_data   (s2_d),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (s2_q)
    );

    assign bus.result = s2_q[W2-1:3];
    assign bus.ovf    = s2_q[2];
    assign bus.unf    = s2_q[1];
    assign bus.zero   = s2_q[0];

`ifdef MUL_EXP_STICKY_FLAGS_EN
    logic sticky_ovf_q;
    logic sticky_unf_q;

    // A clear wins over a set landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf_q <= 1'b0;
            sticky_unf_q <= 1'b0;
        end else if (bus.flag_clr) begin
            sticky_ovf_q <= 1'b0;
            sticky_unf_q <= 1'b0;
        end else if (bus.out_valid && bus.out_ready) begin
            sticky_ovf_q <= sticky_ovf_q | bus.ovf;
            sticky_unf_q <= sticky_unf_q | bus.unf;
        end
    end

    assign bus.sticky_ovf = sticky_ovf_q;
    assign bus.sticky_unf = sticky_unf_q;
`else
    logic unused_flag_clr;
    assign unused_flag_clr = bus.flag_clr;
    assign bus.sticky_ovf  = 1'b0;
    assign bus.sticky_unf  = 1'b0;
`endif
endmodule

// File: tb/tb_mul_exp_pipe.sv
// Self-checking bench for mul_exp_pipe (EXP_W=4, BIAS=7).
// Build with MUL_EXP_STICKY_FLAGS_EN to exercise sticky flags.
module tb_mul_exp_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mul_exp_pipe_if #(.EXP_W(4)) bus ();

    mul_exp_pipe #(.EXP_W(4), .BIAS(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         e1;
        int         e2;
        int         n;
        logic [6:0] exp;
    } vec_t;

    int         nvec = 0;
    int         nerr = 0;
    int         emits = 0;
    logic       acc = 1'b0;
    logic       stall_prev = 1'b0;
    logic [6:0] stall_val = '0;
    logic [6:0] sb[$];

    // Expected {result, ovf, unf, zero} from plain integer arithmetic.
    function automatic logic [6:0] model(int e1, int e2, int n);
        int r;
        r = e1 + e2 + n - 7;
        if (e1 == 0 || e2 == 0) return {4'd0, 3'b001};
        if (r > 15)             return {4'd15, 3'b100};
        if (r <= 0)             return {4'd0, 3'b010};
        return {4'(r), 3'b000};
    endfunction

    function automatic logic [6:0] outv();
        return {bus.result, bus.ovf, bus.unf, bus.zero};
    endfunction

    task automatic chk(string nm, int act, int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load(int a, int b, int n);
        bus.exp1     = 4'(a);
        bus.exp2     = 4'(b);
        bus.norm_inc = 1'(n);
        bus.in_valid = 1'b1;
    endtask

    // One clock: sample handshakes at negedge, return at posedge+1.
    task automatic tick();
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        if (stall_prev) chk("stall_hold", int'(outv()), int'(stall_val));
        if (acc) sb.push_back(model(bus.exp1, bus.exp2, bus.norm_inc));
        if (bus.out_valid && bus.out_ready) begin
            emits++;
            if (sb.size() == 0) chk("spurious_emit", 1, 0);
            else chk("sb_beat", int'(outv()), int'(sb.pop_front()));
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        stall_val  = outv();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string nm);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        chk(nm, sb.size(), 0);
    endtask

    vec_t tab[10];
    int   e0;
    int   idx;
    int   nacc;
    int   sa[3];
    int   sb_e2[3];
    int   sn[3];

    initial begin
        tab[0] = '{9, 10, 0, {4'd12, 3'b000}};
        tab[1] = '{15, 15, 1, {4'd15, 3'b100}};
        tab[2] = '{11, 11, 0, {4'd15, 3'b000}};
        tab[3] = '{2, 3, 0, {4'd0, 3'b010}};
        tab[4] = '{4, 3, 0, {4'd0, 3'b010}};
        tab[5] = '{4, 4, 0, {4'd1, 3'b000}};
        tab[6] = '{0, 15, 1, {4'd0, 3'b001}};
        tab[7] = '{15, 0, 0, {4'd0, 3'b001}};
        tab[8] = '{8, 8, 0, {4'd9, 3'b000}};
        tab[9] = '{11, 11, 1, {4'd15, 3'b100}};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.exp1      = '0;
        bus.exp2      = '0;
        bus.norm_inc  = 1'b0;
        bus.out_ready = 1'b1;
        bus.flag_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_outs", int'(outv()), 0);
        chk("rst_sticky", {bus.sticky_ovf, bus.sticky_unf}, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        // Directed table: one beat at a time, exact 2-cycle latency.
        foreach (tab[i]) begin
            load(tab[i].e1, tab[i].e2, tab[i].n);
            tick();
            bus.in_valid = 1'b0;
            chk("tab_lat1", bus.out_valid, 0);
            tick();
            chk("tab_lat2", bus.out_valid, 1);
            chk("tab_val", int'(outv()), int'(tab[i].exp));
            tick();
        end
        drain("tab_drain");

        // Back-to-back stream of 8 beats, one per cycle.
        e0 = emits;
        for (int i = 0; i < 8; i++) begin
            load(3 + i, 8, i & 1);
            tick();
            chk("stream_acc", acc, 1);
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("stream_emits", emits - e0, 8);
        drain("stream_drain");

        // Output stall with beats A, B, C.
        sa = '{9, 15, 2};
        sb_e2 = '{10, 15, 3};
        sn = '{0, 1, 0};
        idx = 0;
        bus.out_ready = 1'b0;
        load(sa[0], sb_e2[0], sn[0]);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("stall_in_ready", bus.in_ready, (c < 2) ? 1 : 0);
            if (c >= 2) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_head", int'(outv()), int'(model(9, 10, 0)));
            end
            tick();
            if (acc) begin
                idx++;
                if (idx < 3) load(sa[idx], sb_e2[idx], sn[idx]);
                else bus.in_valid = 1'b0;
            end
        end
        chk("stall_accepted", idx, 2);
        bus.out_ready = 1'b1;
        e0 = emits;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (acc) begin
                idx++;
                if (idx < 3) load(sa[idx], sb_e2[idx], sn[idx]);
                else bus.in_valid = 1'b0;
            end
        end
        chk("stall_release", emits - e0, 3);
        drain("stall_drain");

        // Randomized traffic with random backpressure.
        nacc = 0;
        bus.in_valid = 1'b0;
        acc = 1'b0;
        for (int k = 0; k < 4000 && nacc < 400; k++) begin
            if (!bus.in_valid || acc) begin
                if ($urandom_range(0, 3) != 0)
                    load($urandom_range(0, 15), $urandom_range(0, 15),
                         $urandom_range(0, 1));
                else
                    bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (acc) nacc++;
        end
        chk("rand_count", nacc, 400);
        drain("rand_drain");

`ifdef MUL_EXP_STICKY_FLAGS_EN
        bus.flag_clr = 1'b1;
        tick();
        bus.flag_clr = 1'b0;
        chk("sticky_clr", bus.sticky_ovf, 0);
        load(15, 15, 1);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("sticky_ovf_set", bus.sticky_ovf, 1);
        load(2, 3, 0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("sticky_unf_set", bus.sticky_unf, 1);
        load(15, 14, 0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        bus.flag_clr = 1'b1;
        tick();
        bus.flag_clr = 1'b0;
        chk("sticky_clr_prio", bus.sticky_ovf, 0);
`else
        chk("sticky_tied_ovf", bus.sticky_ovf, 0);
        chk("sticky_tied_unf", bus.sticky_unf, 0);
`endif

        // Reset with two beats in flight.
        bus.out_ready = 1'b1;
        load(9, 10, 0);
        tick();
        load(15, 15, 1);
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_outs", int'(outv()), 0);
        sb.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_sticky", {bus.sticky_ovf, bus.sticky_unf}, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_rst_valid", bus.out_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
